// File: rtl/root_arbiter_pkg.sv
// root_arbiter_pkg: shared FSM states and timing constants for the square-root arbiter
package root_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ROOT_ITER = 16;
  localparam int ROOT_LAT = 17;
endpackage

// File: rtl/root_nonrestoring.sv
// root_nonrestoring: 16-iteration non-restoring integer square root, raw signed remainder out
module root_nonrestoring
  import root_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        load,
  input  logic [31:0] d,
  output logic        ready,
  output logic [15:0] q,
  output logic [21:0] r
);
  logic [31:0] d_q, d_d;
  logic [21:0] r_q, r_d, r_sh, trial;
  logic [15:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  // one root bit per cycle: shift in the next radicand pair, add or subtract by remainder sign
  always_comb begin
    r_sh = {r_q[19:0], d_q[31:30]};
    trial = r_q[21] ? r_sh + {4'b0, q_q, 2'b11} : r_sh - {4'b0, q_q, 2'b01};
    d_d = d_q;
    r_d = r_q;
    q_d = q_q;
    cnt_d = cnt_q;
    ready_d = ready_q;
    if (load) begin
      d_d = d;
      r_d = '0;
      q_d = '0;
      cnt_d = 5'(ROOT_ITER);
      ready_d = 1'b0;
    end else if (cnt_q != 5'd0) begin
      d_d = {d_q[29:0], 2'b00};
      r_d = trial;
      q_d = {q_q[14:0], ~trial[21]};
      cnt_d = cnt_q - 5'd1;
      ready_d = cnt_q == 5'd1;
    end
  end
  // iteration state registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      d_q <= '0;
      r_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      d_q <= d_d;
      r_q <= r_d;
      q_q <= q_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
    end
  end
  assign ready = ready_q;
  assign q = q_q;
  assign r = r_q;
endmodule

// File: rtl/root_arbiter.sv
// root_arbiter: round-robin sharing of one square-root unit among NREQ requesters
module root_arbiter
  import root_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_d,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_q,
  output logic [16:0]        rsp_r,
  output logic               busy
);
  state_t           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d, last_q, last_d, win;
  logic             first_q, first_d, load, u_ready;
  logic [15:0]      res_q_q, res_q_d, u_q;
  logic [16:0]      res_r_q, res_r_d, r_adj;
  logic [21:0]      u_r;
  logic [31:0]      u_d;

  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] last);
    logic [IDW-1:0] w;
    int idx;
    w = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (v[idx]) w = IDW'(idx);
    end
    return w;
  endfunction

  root_nonrestoring u_root (
    .clk   (clk),
    .clrn  (clrn),
    .load  (load),
    .d     (u_d),
    .ready (u_ready),
    .q     (u_q),
    .r     (u_r)
  );

  // arbitration, issue and result capture; the cycle right after load never trusts unit ready
  always_comb begin
    win = rr_pick(req_valid, last_q);
    u_d = req_d[32*win +: 32];
    r_adj = u_r[21] ? 17'(u_r + {5'b0, u_q, 1'b1}) : u_r[16:0];
    state_d = state_q;
    id_d = id_q;
    last_d = last_q;
    first_d = 1'b0;
    res_q_d = res_q_q;
    res_r_d = res_r_q;
    req_ready = '0;
    load = 1'b0;
    case (state_q)
      IDLE: if (|req_valid) begin
        req_ready = NREQ'(1) << win;
        load = 1'b1;
        id_d = win;
        last_d = win;
        first_d = 1'b1;
        state_d = RUN;
      end
      RUN: if (!first_q && u_ready) begin
        res_q_d = u_q;
        res_r_d = r_adj;
        state_d = DONE;
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // control and result registers; last_id resets so requester 0 wins first
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      id_q <= '0;
      last_q <= IDW'(NREQ - 1);
      first_q <= 1'b0;
      res_q_q <= '0;
      res_r_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      last_q <= last_d;
      first_q <= first_d;
      res_q_q <= res_q_d;
      res_r_q <= res_r_d;
    end
  end

  assign rsp_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign rsp_id = id_q;
  assign rsp_q = res_q_q;
  assign rsp_r = res_r_q;
endmodule

// File: tb/tb_root_arbiter.sv
// tb_root_arbiter: table vectors, directed corner sequences and randomized model check
module tb_root_arbiter;
  import root_arbiter_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0, clrn = 1'b0, rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [32*N-1:0] req_d = '0;
  logic rsp_valid, busy;
  logic [1:0] rsp_id;
  logic [15:0] rsp_q;
  logic [16:0] rsp_r;
  int errs = 0, checks = 0, cyc = 0;

  typedef struct {logic [3:0] valid; logic [31:0] d; logic [1:0] id; logic [15:0] q; logic [16:0] r;} vec_t;
  vec_t tbl[9];

  root_arbiter #(.NREQ(N)) dut (
    .clk(clk), .clrn(clrn), .req_valid(req_valid), .req_d(req_d), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_r(rsp_r), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] isqrt(input logic [31:0] d);
    longint q, t, dd;
    q = 0;
    dd = longint'({32'b0, d});
    for (int b = 15; b >= 0; b--) begin
      t = q + (longint'(1) << b);
      if (t * t <= dd) q = t;
    end
    return 16'(q);
  endfunction

  function automatic logic [16:0] irem(input logic [31:0] d);
    longint q;
    q = longint'(isqrt(d));
    return 17'(longint'({32'b0, d}) - q * q);
  endfunction

  function automatic int rr_model(input logic [3:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    clrn = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_q", rsp_q, 0);
    chk("rst_r", rsp_r, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(posedge clk);
    #1 req_valid = v.valid;
    req_d = {N{v.d}};
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("vec_grant", req_ready, 4'b1 << v.id);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(n);
    chk("vec_latency", n, ROOT_LAT);
    chk("vec_id", rsp_id, v.id);
    chk("vec_q", rsp_q, v.q);
    chk("vec_r", rsp_r, v.r);
    @(posedge clk);
    #1 chk("vec_release", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, t_prev, m_phase, m_cnt, m_last, m_id, w, done;
    logic [31:0] m_d;
    logic [3:0] exp_rdy;
    logic seen;
    int fq[5] = '{10, 14, 17, 20, 10};
    int fr[5] = '{0, 4, 11, 0, 0};
    int fid[5] = '{0, 1, 2, 3, 0};
    tbl[0] = '{4'b0001, 32'd16, 2'd0, 16'd4, 17'd0};
    tbl[1] = '{4'b0001, 32'hFFFF_FFFF, 2'd0, 16'hFFFF, 17'h1FFFE};
    tbl[2] = '{4'b0011, 32'd0, 2'd1, 16'd0, 17'd0};
    tbl[3] = '{4'b1111, 32'd2, 2'd2, 16'd1, 17'd1};
    tbl[4] = '{4'b1011, 32'd1, 2'd3, 16'd1, 17'd0};
    tbl[5] = '{4'b1110, 32'd3, 2'd1, 16'd1, 17'd2};
    tbl[6] = '{4'b0101, 32'd1000000, 2'd2, 16'd1000, 17'd0};
    tbl[7] = '{4'b1000, 32'hFFFE_0001, 2'd3, 16'hFFFF, 17'd0};
    tbl[8] = '{4'b0010, 32'h8000_0000, 2'd1, 16'hB504, 17'd88048};
    do_reset();
    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // fairness with rsp_ready tied high: ID order and 19-cycle issue interval
    do_reset();
    req_d = {32'd400, 32'd300, 32'd200, 32'd100};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(n);
      if (i > 0) chk("fair_interval", cyc - t_prev, 19);
      t_prev = cyc;
      chk("fair_id", rsp_id, fid[i]);
      chk("fair_q", rsp_q, fq[i]);
      chk("fair_r", rsp_r, fr[i]);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    // backpressure: result held, requests ignored, one handshake on release
    req_d = {N{32'd400}};
    @(posedge clk);
    #1 req_valid = 4'b1111;
    wait_rsp(n);
    chk("bp_id", rsp_id, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_q", rsp_q, 20);
      chk("bp_r", rsp_r, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_single", rsp_valid, 0);
    end

    // reset at cycle 8 of RUN drops the operation
    req_d = {N{32'd1234567}};
    @(posedge clk);
    #1 req_valid = 4'b0100;
    @(posedge clk);
    #1 req_valid = '0;
    repeat (7) @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_id", rsp_id, 0);
    chk("mid_q", rsp_q, 0);
    chk("mid_r", rsp_r, 0);
    chk("mid_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("mid_no_rsp", seen, 0);
    run_vec('{4'b1111, 32'd81, 2'd0, 16'd9, 17'd0});

    // randomized traffic against the behavioural model
    do_reset();
    m_phase = 0;
    m_cnt = 0;
    m_last = N - 1;
    m_id = 0;
    m_d = '0;
    done = 0;
    for (int c = 0; c < 60000 && done < 1000; c++) begin
      @(posedge clk);
      #1 req_valid = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      for (int l = 0; l < N; l++) begin
        case ($urandom_range(0, 7))
          0: req_d[32*l +: 32] = 32'd0;
          1: req_d[32*l +: 32] = 32'hFFFF_FFFF;
          2: req_d[32*l +: 32] = 32'($urandom_range(0, 100));
          default: req_d[32*l +: 32] = $urandom;
        endcase
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      w = rr_model(req_valid, m_last);
      exp_rdy = (m_phase == 0 && w >= 0) ? 4'b1 << w : 4'b0;
      chk("rnd_req_ready", req_ready, exp_rdy);
      chk("rnd_rsp_valid", rsp_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("rnd_id", rsp_id, m_id);
        chk("rnd_q", rsp_q, isqrt(m_d));
        chk("rnd_r", rsp_r, irem(m_d));
      end
      if (m_phase == 0 && w >= 0) begin
        m_id = w;
        m_last = w;
        m_d = req_d[32*w +: 32];
        m_phase = 1;
        m_cnt = ROOT_LAT;
      end else if (m_phase == 1) begin
        m_cnt--;
        if (m_cnt == 0) m_phase = 2;
      end else if (m_phase == 2 && rsp_ready) begin
        m_phase = 0;
        done++;
      end
    end
    chk("rnd_count", done, 1000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
